// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC normalize-and-round stage.
// Holds the datapath widths, the S1 pipeline record and the output record
// handed to the downstream packer.
package fp_mac_pkg;

    localparam int WIDTH  = 74;                  // adder result width (magnitude is WIDTH+1 with carry)
    localparam int MANT_W = 24;                  // rounded mantissa width, hidden bit included
    localparam int EXP_W  = 10;                  // signed exponent width
    localparam int LZ_W   = $clog2(WIDTH + 2);   // holds counts 0..WIDTH+1

    // Captured beat in stage 1: raw magnitude plus its leading-zero count.
    typedef struct packed {
        logic [WIDTH:0]     mag;
        logic [EXP_W-1:0]   exp;
        logic               sign;
        logic [LZ_W-1:0]    lz;
    } s1_t;

    // Normalized, rounded result presented on the output port.
    typedef struct packed {
        logic [MANT_W-1:0]  mant;
        logic [EXP_W-1:0]   exp;
        logic               sign;
        logic               zero;
        logic               inexact;
    } norm_out_t;

endpackage

// File: rtl/fp_mac_norm_round_lzc.sv
// Combinational leading-zero counter.
// Ports:
//   din - vector to scan, MSB first
//   cnt - number of zeros above the most significant 1; W when din is all zero
module lzc #(
    parameter int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Ascending scan: the last hit (the highest set bit) wins.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_mac_norm_round.sv
// Normalize-and-round stage downstream of the FP MAC adder.
// Two register stages: S1 captures the raw {carry, sum} magnitude with its
// leading-zero count; S2 shifts, rounds to nearest-even and registers the
// result. Valid/ready handshake on both sides, one beat per cycle.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready        - input handshake (in_ready is combinational from out_ready)
//   in_carry, in_sum         - adder carry-out and result, forming a WIDTH+1 bit magnitude
//   in_exp, in_sign          - signed exponent of bit WIDTH-1, result sign
//   out_valid/out_ready      - output handshake; out_* hold while stalled
//   out_mant, out_exp        - rounded mantissa (hidden bit at MSB) and adjusted exponent
//   out_sign, out_zero       - sign pass-through, exact-zero flag
//   out_inexact              - guard or sticky bits were nonzero
module fp_mac_norm_round
    import fp_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_carry,
    input  logic [WIDTH-1:0]  in_sum,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_inexact
);

    localparam int GRD = WIDTH - MANT_W;   // bit position of the guard bit in N

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic      s1_valid_reg;
    logic      s2_valid_reg;
    s1_t       s1_reg;
    norm_out_t s2_reg;
    norm_out_t s2_next;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_adv;
    // Held low while rst is asserted so nothing is accepted during reset.
    assign in_ready = !rst && (!s1_valid_reg || s2_adv);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // S1: capture magnitude and its leading-zero count
    // ------------------------------------------------------------------
    logic [WIDTH:0]  mag_w;
    logic [LZ_W-1:0] lz_w;

    assign mag_w = {in_carry, in_sum};

    lzc #(.W(WIDTH + 1)) u_lzc (
        .din (mag_w),
        .cnt (lz_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else begin
            // in_ready means S1 is empty or draining this cycle, so it takes
            // whatever is offered (or becomes a bubble).
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (accept) begin
                s1_reg <= '{mag: mag_w, exp: in_exp, sign: in_sign, lz: lz_w};
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: normalize, round to nearest even, adjust exponent
    // ------------------------------------------------------------------
    logic [WIDTH:0]    norm_w;
    logic [MANT_W-1:0] mant_raw;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_inc;
    logic              rnd_ovf;
    logic [MANT_W-1:0] mant_rnd;
    logic [EXP_W:0]    exp_ext;
    logic              is_zero;

    assign norm_w   = s1_reg.mag << s1_reg.lz;
    assign mant_raw = norm_w[WIDTH -: MANT_W];
    assign guard    = norm_w[GRD];
    assign sticky   = |norm_w[GRD-1:0];
    assign round_up = guard && (sticky || mant_raw[0]);
    assign mant_inc = {1'b0, mant_raw} + {{MANT_W{1'b0}}, round_up};
    assign rnd_ovf  = mant_inc[MANT_W];
    // Carry out of an all-ones mantissa renormalizes to 1.000...
    assign mant_rnd = rnd_ovf ? {1'b1, {(MANT_W-1){1'b0}}} : mant_inc[MANT_W-1:0];
    assign is_zero  = ~|s1_reg.mag;

    // in_exp names bit WIDTH-1, so an unshifted carry bit is one above it.
    // Computed one bit wider and truncated; range checks happen downstream.
    assign exp_ext = {s1_reg.exp[EXP_W-1], s1_reg.exp}
                   + (EXP_W+1)'(1)
                   - {{(EXP_W+1-LZ_W){1'b0}}, s1_reg.lz}
                   + {{EXP_W{1'b0}}, rnd_ovf};

    always_comb begin
        s2_next         = '0;
        s2_next.sign    = s1_reg.sign;
        s2_next.zero    = is_zero;
        if (!is_zero) begin
            s2_next.mant    = mant_rnd;
            s2_next.exp     = exp_ext[EXP_W-1:0];
            s2_next.inexact = guard || sticky;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_reg       <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            // Data only moves with a real beat, so a bubble leaves outputs untouched.
            if (s1_adv) begin
                s2_reg <= s2_next;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_mant    = s2_reg.mant;
    assign out_exp     = s2_reg.exp;
    assign out_sign    = s2_reg.sign;
    assign out_zero    = s2_reg.zero;
    assign out_inexact = s2_reg.inexact;

endmodule

// File: doc/fp_mac_norm_round.md
Name: fp_mac_norm_round

Overview:
- Pipelined normalize-and-round stage that sits directly downstream of the FP MAC adder.
- Consumes the raw `{carry, res}` sum (WIDTH+1 bits) together with the sign and the pre-normalization exponent.
- Normalizes the value with a leading-zero count and left shift, then rounds to MANT_W bits using round-to-nearest-even (RNE).
- Produces a normalized mantissa, an adjusted exponent and status flags for the downstream packer; valid/ready handshake on both sides.

Parameters:
- WIDTH, 74, adder result width; the input magnitude is WIDTH+1 bits including carry
- MANT_W, 24, output mantissa width including hidden bit
- EXP_W, 10, signed exponent width (two's complement)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- in_carry  input  1  adder carry-out, bit WIDTH of the magnitude
- in_sum  input  WIDTH  adder result, bits WIDTH-1:0 of the magnitude
- in_exp  input  EXP_W  signed exponent of bit WIDTH-1
- in_sign  input  1  result sign
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_mant  output  MANT_W  normalized, rounded mantissa; MSB is the hidden 1 unless zero
- out_exp  output  EXP_W  adjusted signed exponent
- out_sign  output  1  passed through
- out_zero  output  1  exact zero result
- out_inexact  output  1  guard OR sticky was nonzero

Behaviour:
- Reset (async, active-high):
  - All valid flags go to 0.
  - out_mant, out_exp, out_sign, out_zero and out_inexact go to 0.
  - in_ready goes to 1 once rst deasserts; it is 1 whenever S1 is empty.
  - Assertion mid-operation discards all in-flight beats; none are emitted after reset.
- Pipeline: two register stages; latency is exactly 2 cycles from acceptance to out_valid when there is no stall.
- S1 (capture):
  - Registers magnitude M = {in_carry, in_sum}, in_exp, in_sign.
  - Registers lz = leading-zero count of M, range 0..WIDTH+1.
- S2 (compute and register outputs):
  - N = (M << lz), truncated to WIDTH+1 bits.
  - Field split of N:
    - mant = N[WIDTH : WIDTH-MANT_W+1]
    - guard = N[WIDTH-MANT_W]
    - sticky = OR of N[WIDTH-MANT_W-1 : 0]
  - RNE: increment mant when guard & (sticky | mant[0]).
  - If the increment overflows (mant was all ones): out_mant = 1 followed by zeros, and the exponent gets +1.
  - out_exp = in_exp + 1 - lz (+1 on round overflow).
  - Arithmetic is in EXP_W+1 bits, truncated to EXP_W. There is no saturation here; overflow/underflow detection belongs downstream.
  - out_inexact = guard | sticky.
- Zero: when M == 0 (lz = WIDTH+1): out_zero=1, out_mant=0, out_exp=0, out_inexact=0; out_sign passes through.
- Handshake:
  - Beat accepted on in_valid & in_ready; beat leaves on out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready
  - s1_adv = s1_valid & s2_adv
  - in_ready = !s1_valid | s2_adv. This is combinational from out_ready; documented, no skid buffer.
  - While out_valid & !out_ready, all out_* signals hold stable.
  - Simultaneous accept and emit in one cycle gives full throughput of one beat per cycle.
  - Beats are never dropped, duplicated or reordered.
- Bubbles: S2 loads a bubble (s2_valid=0) when s2_adv & !s1_valid. Data registers may hold stale values while invalid.

Decomposition:
- Package fp_mac_pkg:
  - WIDTH, MANT_W, EXP_W localparams
  - typedef s1_t (magnitude, exp, sign, lz)
  - typedef norm_out_t (mant, exp, sign, zero, inexact)
  - LZ_W = $clog2(WIDTH+2)
- Sub-module lzc (parameter W): combinational leading-zero count; returns W for an all-zero input. Instantiated once in S1.

Test Plan (WIDTH=74, MANT_W=24, out_ready=1 unless stated):
- MSB-only: in_carry=0, in_sum=1<<73, in_exp=5 -> after 2 cycles out_mant=0x800000, out_exp=5, inexact=0.
- Carry: in_carry=1, in_sum=0, in_exp=5 -> out_mant=0x800000, out_exp=6. Then in_sum=1, in_carry=0, in_exp=0 -> out_mant=0x800000, out_exp=-73.
- Rounding:
  - in_sum[73:50]=0x800000, bit49=1, rest 0 (tie, even) -> out_mant=0x800000, inexact=1.
  - Same plus bit0=1 -> out_mant=0x800001.
  - in_sum[73:50]=0xFFFFFF, bit49=1, in_exp=5 -> out_mant=0x800000, out_exp=6.
- Zero: in_carry=0, in_sum=0, in_sign=1 -> out_zero=1, out_mant=0, out_exp=0, out_sign=1.
- Backpressure: stream 5 beats with in_valid=1 while out_ready=0 -> exactly 2 accepted, then in_ready=0. Outputs hold stable. Raising out_ready drains all 5 in order at 1 beat/cycle with no loss or duplication.
- Reset mid-operation: assert rst while 2 beats are in flight -> out_valid=0 and outputs=0 immediately (async); after release in_ready=1 and no stale beat emerges.
